// File: rtl/ram_cbus_adapter.sv
// cbus request/response adapter in front of a single-port RAM.
// Sequences INCR/WRAP bursts one beat at a time and absorbs the RAM read latency.
module ram_cbus_adapter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_is_write,
    input  logic [63:0]             req_addr,
    input  logic [3:0]              req_len,
    input  logic                    req_burst,
    input  logic [DATA_WIDTH/8-1:0] req_strobe,
    input  logic [DATA_WIDTH-1:0]   req_data,
    output logic                    resp_ready,
    output logic                    resp_last,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    ram_en,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH/8-1:0] ram_strobe,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] base;
    logic [3:0]            len;
    logic                  burst;
    logic                  is_write;
    logic [3:0]            beat, beat_nx;
    logic [2:0]            cnt, cnt_nx;
    logic                  load;
    logic                  ack;
    logic                  last;
    logic [ADDR_WIDTH-1:0] len_mask;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  unused_addr_bits;

    assign unused_addr_bits = &{1'b0, req_addr[63:ADDR_WIDTH+3], req_addr[2:0]};

    // WRAP keeps the bits above the burst length fixed and lets the low bits roll over.
    assign len_mask  = ADDR_WIDTH'(len);
    assign incr_addr = base + ADDR_WIDTH'(beat);
    assign beat_addr = burst ? ((base & ~len_mask) | (incr_addr & len_mask)) : incr_addr;
    assign last      = (beat == len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            base     <= '0;
            len      <= '0;
            burst    <= 1'b0;
            is_write <= 1'b0;
            beat     <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
            cnt   <= cnt_nx;
            if (load) begin
                base     <= req_addr[ADDR_WIDTH+2:3];
                len      <= req_len;
                burst    <= req_burst;
                is_write <= req_is_write;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        beat_nx    = beat;
        cnt_nx     = cnt;
        load       = 1'b0;
        ack        = 1'b0;
        resp_ready = 1'b0;
        resp_last  = 1'b0;
        resp_data  = '0;
        ram_en     = 1'b0;
        ram_addr   = '0;
        ram_strobe = '0;
        ram_wdata  = '0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    load     = 1'b1;
                    beat_nx  = '0;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                ram_addr = beat_addr;
                if (is_write) begin
                    ram_en     = 1'b1;
                    ram_strobe = req_strobe;
                    ram_wdata  = req_data;
                    ack        = 1'b1;
                end else if (READ_LATENCY == 0) begin
                    ack = 1'b1;
                end else begin
                    cnt_nx   = 3'(READ_LATENCY);
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                ram_addr = beat_addr;
                cnt_nx   = cnt - 3'd1;
                ack      = (cnt == 3'd1);
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Shared beat acknowledge for writes, zero-latency reads and the final wait cycle.
        if (ack) begin
            resp_ready = 1'b1;
            resp_last  = last;
            resp_data  = is_write ? '0 : ram_rdata;
            if (last) begin
                state_nx = DONE;
            end else begin
                beat_nx  = beat + 4'd1;
                state_nx = ISSUE;
            end
        end
    end

endmodule

// File: doc/ram_cbus_adapter.md
Name: ram_cbus_adapter

Overview:
- Upstream stage for the single-port RAM. Accepts burst requests on the team's cbus request/response handshake and drives the RAM port (en/addr/strobe/wdata, rdata back).
- Handles the RAM's configurable read latency and INCR/WRAP burst address sequencing.
- One request outstanding at a time. Used as the simulation/FPGA memory endpoint behind the core's bus.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width; must match the RAM instance.
- DATA_WIDTH, 64, word width; fixed at 64 (8-byte strobe).
- READ_LATENCY, 0, RAM read latency in cycles (0..4); must match the RAM instance.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  request valid; held until the last beat is acknowledged
- req_is_write  in  1  1 = write burst
- req_addr  in  64  byte address; bits [2:0] ignored
- req_len  in  4  beats minus 1; legal values 0, 1, 3, 7, 15
- req_burst  in  1  0 = INCR, 1 = WRAP
- req_strobe  in  8  per-byte write enable for the current beat
- req_data  in  64  write data for the current beat; requester advances it after each acknowledged beat
- resp_ready  out  1  beat acknowledged; read data valid
- resp_last  out  1  current acknowledged beat is the final beat
- resp_data  out  64  read data; 0 when resp_ready=0 or on writes
- ram_en  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM word address
- ram_strobe  out  8  RAM byte strobes
- ram_wdata  out  64  RAM write data
- ram_rdata  in  64  RAM read data

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - resp_ready, resp_last, resp_data, ram_en, ram_strobe, ram_wdata, ram_addr all 0.
  - A reset mid-burst abandons the burst. Beats already written remain in RAM.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Outputs idle.
  - On req_valid=1, latch base = req_addr[ADDR_WIDTH+2:3], len, burst, is_write; set beat=0; next state ISSUE.
  - First beat is issued the following cycle.
- Beat address:
  - INCR: (base+beat) mod 2^ADDR_WIDTH; wraps silently at the top of memory.
  - WRAP: (base & ~len) | ((base+beat) & len).
  - ram_addr is held at the beat address for the whole beat.
- ISSUE, write:
  - ram_en=1, ram_strobe=req_strobe, ram_wdata=req_data, resp_ready=1, resp_last=(beat==len).
  - Last beat -> DONE; otherwise beat++ and stay in ISSUE. Throughput is one beat per cycle.
- ISSUE, read, READ_LATENCY=0:
  - ram_en=0, ram_strobe=0, resp_ready=1, resp_data=ram_rdata (same cycle), resp_last=(beat==len).
  - Beat sequencing as for writes.
- ISSUE, read, READ_LATENCY=L>0:
  - Present the address with resp_ready=0; load cnt=L; next state WAIT.
- WAIT:
  - Hold the address; decrement cnt each cycle.
  - In the cycle where cnt==1: resp_ready=1, resp_data=ram_rdata, resp_last=(beat==len).
  - Then go to DONE if this was the last beat, else beat++ and return to ISSUE.
  - Each read beat occupies exactly L+1 cycles.
- DONE:
  - One cycle with all outputs idle. req_valid is ignored so the still-held request is not re-accepted.
  - Next state IDLE. A new request is accepted the cycle after DONE at the earliest.
- Request inputs other than req_strobe/req_data are sampled only in IDLE. Changes during a burst are ignored.
- Illegal req_len values (e.g. 2) with WRAP: behaviour follows the mask formula; no error signalled.
- ram_strobe is always 0 when ram_en=0. The adapter never issues a write during a read burst.

Test Plan:
- L=1: write addr 0x40, len 0, strobe 0xFF, data 0xDEADBEEF -> resp_ready=1 and resp_last=1 in cycle 1. Then read 0x40 -> resp_ready in cycle 2 with data 0xDEADBEEF.
- L=0: INCR read, len 3, base word 4 (pre-filled 4..7 = 0x10..0x13) -> resp_ready high on 4 consecutive cycles with data 0x10..0x13; resp_last only on the 4th; then a DONE idle cycle.
- L=2: WRAP read, len 3, addr word 6 -> ram_addr sequence 6,7,4,5. Each beat spaced 3 cycles apart; resp_ready is a single-cycle pulse per beat.
- Partial strobe: write 0x1122334455667788 with strobe 0xFF, then 0xAAAAAAAAAAAAAAAA with strobe 0x0F -> read returns 0x11223344AAAAAAAA.
- INCR write, len 1, at word 2^ADDR_WIDTH-1 -> second beat writes word 0.
- Assert reset during beat 2 of a len-7 write -> outputs 0 immediately (asynchronously); words 0..1 written, word 2 onward unchanged. A new request after reset completes normally.
